load_store_unit: RTL
====================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter ADDR_BUS_WIDTH, default 32, meaning request/memory address width.
REQ-002 SHALL have parameter DATA_BUS_WIDTH, default 32, meaning data word width (byte-lane logic is fixed at 4 bytes).
REQ-003 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  in  1  reset, synchronous and active-high.
REQ-005 SHALL have ports req_valid in 1 and req_ready out 1, the pipeline request handshake.
REQ-006 SHALL have ports req_write in 1, req_funct3 in 3, req_addr in ADDR_BUS_WIDTH and req_wdata in DATA_BUS_WIDTH, the request payload.
REQ-007 SHALL have ports rsp_valid out 1, rsp_rdata out DATA_BUS_WIDTH and rsp_err out 1, the completion response.
REQ-008 SHALL have ports mem_addr out ADDR_BUS_WIDTH, mem_write_data out DATA_BUS_WIDTH, mem_write_en out 1 and mem_read_data in DATA_BUS_WIDTH, the data-memory side.

Function
REQ-009 SHALL accept a request when req_valid && req_ready; req_ready SHALL be 1 only in state IDLE.
REQ-010 SHALL implement FSM states IDLE, LOAD, RMW_READ, WRITE and RESP.
REQ-011 SHALL encode funct3 as 000 byte, 001 half, 010 word, 100 byte-unsigned, 101 half-unsigned; 100/101 are loads only.
REQ-012 SHALL drive mem_addr = {addr[ADDR_BUS_WIDTH-1:2], 2'b00} from the registered request, or 0 in IDLE/RESP.
REQ-013 SHALL use big-endian lanes: offset 0 = bits [31:24], offset 3 = [7:0]; half offset 0 = [31:16], offset 2 = [15:0].
REQ-014 Load: IDLE -> LOAD (capture extracted, sign- or zero-extended lane) -> RESP; rsp_valid is asserted 2 cycles after acceptance.
REQ-015 Word store: IDLE -> WRITE (mem_write_en=1, mem_write_data=wdata) -> RESP; rsp_valid is asserted 2 cycles after acceptance.
REQ-016 Sub-word store: IDLE -> RMW_READ (capture mem_read_data) -> WRITE (captured word with target lane replaced by wdata low bits) -> RESP; rsp_valid is asserted 3 cycles after acceptance.
REQ-017 SHALL pulse rsp_valid for exactly the one RESP cycle; RESP -> IDLE unconditionally.
REQ-018 rsp_rdata SHALL hold the last load result until the next load completes; stores SHALL leave it unchanged.
REQ-019 An illegal funct3 (store 011/1xx, load 011/11x) SHALL perform no memory access: IDLE -> RESP with rsp_err=1.
REQ-020 mem_write_en SHALL be 1 only in WRITE and SHALL be gated by !reset.

Reset
REQ-021 On reset, the FSM SHALL go to IDLE, with rsp_valid=0, rsp_err=0, rsp_rdata=0, req_ready=1 after the edge, mem_write_en=0 and mem_addr=0.
REQ-022 Reset asserted in any state, including RMW_READ or WRITE, SHALL abort the operation with no memory write and no response.

Configuration
REQ-023 Macro LSU_MISALIGN_TRAP_EN SHALL control misaligned-access handling.
REQ-024 With the macro defined, a half access with addr[0]=1 or a word access with addr[1:0]!=0 SHALL do no memory access: IDLE -> RESP with rsp_err=1.
REQ-025 With the macro undefined, offset bits SHALL be truncated to natural alignment (half: addr[0] ignored; word: addr[1:0] ignored), and rsp_err SHALL be set only by REQ-019.

Structure
REQ-026 Package lsu_pkg SHALL hold the FSM state type, the funct3 constants and the byte-width constant (8).
REQ-027 One combinational sub-module, lsu_lane_align, SHALL perform load extract/extend and store merge; the FSM and registers stay in load_store_unit.

Verification
REQ-028 Memory word at 8 = 0xAAAAAAAA; LB at addr 8 -> rsp_rdata 0xFFFFFFAA, rsp_valid 2 cycles after accept.
REQ-029 Same word; LBU at addr 9 -> 0x000000AA; LHU at addr 10 -> 0x0000AAAA; LH at addr 10 -> 0xFFFFAAAA.
REQ-030 Word at 4 = 0x33333333; SB at addr 5 with wdata 0x000000FF -> a single WRITE with mem_write_data 0x33FF3333 and mem_addr 4; rsp_valid at cycle +3.
REQ-031 SW at addr 12 with 0xDEADBEEF, then LW at addr 12 -> rsp_rdata 0xDEADBEEF; req_ready is low during each operation.
REQ-032 LW at addr 6: macro defined -> rsp_err=1, no mem_write_en, rsp_valid at +1; macro undefined -> word at 4 returned, rsp_err=0.
REQ-033 SH at addr 0, reset asserted in the RMW_READ cycle -> no mem_write_en pulse, no rsp_valid, IDLE with req_ready=1 after the reset edge.

Source files
------------

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the load/store unit.
//   - lsu_state_t  : FSM state encoding
//   - F3_*         : funct3 access-size encodings
//   - BYTE_W       : width of one byte lane
//   - funct3_legal : whether a funct3 code is a legal load or store
package lsu_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RMW_READ,
    WRITE,
    RESP
  } lsu_state_t;

  localparam logic [2:0] F3_BYTE  = 3'b000;
  localparam logic [2:0] F3_HALF  = 3'b001;
  localparam logic [2:0] F3_WORD  = 3'b010;
  localparam logic [2:0] F3_BYTEU = 3'b100;
  localparam logic [2:0] F3_HALFU = 3'b101;

  localparam int BYTE_W = 8;

  // Unsigned variants only make sense for loads; stores accept the three sizes.
  function automatic logic funct3_legal(input logic write, input logic [2:0] f3);
    logic sized;
    sized = (f3 == F3_BYTE) || (f3 == F3_HALF) || (f3 == F3_WORD);
    if (write) return sized;
    return sized || (f3 == F3_BYTEU) || (f3 == F3_HALFU);
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: combinational byte-lane steering for the load/store unit.
// Lanes are big-endian: byte offset 0 is bits [31:24], offset 3 is [7:0];
// half offset 0 is [31:16], offset 2 is [15:0]. Half accesses look only at
// offset[1], so an odd half address is truncated to natural alignment.
// Ports:
//   funct3     in  3  access size / signedness
//   offset     in  2  byte offset within the word
//   rdata      in  W  word read from memory (load source)
//   word_in    in  W  previously read word (store merge base)
//   wdata      in  W  store data, low bits used for sub-word stores
//   load_data  out W  extracted and sign/zero-extended load result
//   store_data out W  word to write back to memory
module lsu_lane_align
  import lsu_pkg::*;
#(
  parameter int W = 32
) (
  input  logic [2:0]   funct3,
  input  logic [1:0]   offset,
  input  logic [W-1:0] rdata,
  input  logic [W-1:0] word_in,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] load_data,
  output logic [W-1:0] store_data
);

  logic [BYTE_W-1:0]   byte_sel;
  logic [2*BYTE_W-1:0] half_sel;

  always_comb begin
    byte_sel = '0;
    case (offset)
      2'd0: byte_sel = rdata[31:24];
      2'd1: byte_sel = rdata[23:16];
      2'd2: byte_sel = rdata[15:8];
      2'd3: byte_sel = rdata[7:0];
      default: byte_sel = '0;
    endcase
    half_sel = offset[1] ? rdata[15:0] : rdata[31:16];

    load_data = rdata;
    case (funct3)
      F3_BYTE:  load_data = {{(W-BYTE_W){byte_sel[BYTE_W-1]}}, byte_sel};
      F3_HALF:  load_data = {{(W-2*BYTE_W){half_sel[2*BYTE_W-1]}}, half_sel};
      F3_BYTEU: load_data = {{(W-BYTE_W){1'b0}}, byte_sel};
      F3_HALFU: load_data = {{(W-2*BYTE_W){1'b0}}, half_sel};
      default:  load_data = rdata;
    endcase
  end

  // Sub-word stores replace one lane of the previously read word.
  always_comb begin
    store_data = word_in;
    case (funct3)
      F3_BYTE: begin
        case (offset)
          2'd0: store_data[31:24] = wdata[7:0];
          2'd1: store_data[23:16] = wdata[7:0];
          2'd2: store_data[15:8]  = wdata[7:0];
          2'd3: store_data[7:0]   = wdata[7:0];
          default: store_data = word_in;
        endcase
      end
      F3_HALF: begin
        if (offset[1]) store_data[15:0] = wdata[15:0];
        else           store_data[31:16] = wdata[15:0];
      end
      default: store_data = wdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding load/store engine between a pipeline
// request port and a word-addressed data memory with combinational read.
// Loads take LOAD -> RESP, word stores WRITE -> RESP, sub-word stores do a
// read-modify-write (RMW_READ -> WRITE -> RESP). Illegal requests skip memory.
// Optional feature: define LSU_MISALIGN_TRAP_EN to reject misaligned half/word
// accesses with rsp_err instead of truncating the offset.
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   req_valid/req_ready         request handshake (ready only in IDLE)
//   req_write, req_funct3,
//   req_addr, req_wdata         request payload
//   rsp_valid, rsp_rdata,
//   rsp_err                     one-cycle completion response
//   mem_addr, mem_write_data,
//   mem_write_en, mem_read_data data memory port
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_BUS_WIDTH = 32,
  parameter int DATA_BUS_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_write,
  input  logic [2:0]                req_funct3,
  input  logic [ADDR_BUS_WIDTH-1:0] req_addr,
  input  logic [DATA_BUS_WIDTH-1:0] req_wdata,
  output logic                      rsp_valid,
  output logic [DATA_BUS_WIDTH-1:0] rsp_rdata,
  output logic                      rsp_err,
  output logic [ADDR_BUS_WIDTH-1:0] mem_addr,
  output logic [DATA_BUS_WIDTH-1:0] mem_write_data,
  output logic                      mem_write_en,
  input  logic [DATA_BUS_WIDTH-1:0] mem_read_data
);

  lsu_state_t                state, next_state;
  logic                      write_q, err_q;
  logic [2:0]                funct3_q;
  logic [ADDR_BUS_WIDTH-1:0] addr_q;
  logic [DATA_BUS_WIDTH-1:0] wdata_q, rmw_q, rdata_q;
  logic [DATA_BUS_WIDTH-1:0] load_data, store_data;
  logic                      accept, misaligned, bad_req;

  assign accept = req_valid && (state == IDLE);

`ifdef LSU_MISALIGN_TRAP_EN
  assign misaligned = (((req_funct3 == F3_HALF) || (req_funct3 == F3_HALFU)) && req_addr[0])
                    || ((req_funct3 == F3_WORD) && (req_addr[1:0] != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  assign bad_req = !funct3_legal(req_write, req_funct3) || misaligned;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (bad_req)                     next_state = RESP;
          else if (!req_write)             next_state = LOAD;
          else if (req_funct3 == F3_WORD)  next_state = WRITE;
          else                             next_state = RMW_READ;
        end
      end
      LOAD:     next_state = RESP;
      RMW_READ: next_state = WRITE;
      WRITE:    next_state = RESP;
      RESP:     next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  // Request capture, RMW base word and the sticky load result.
  always_ff @(posedge clk) begin
    if (reset) begin
      write_q  <= 1'b0;
      err_q    <= 1'b0;
      funct3_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rmw_q    <= '0;
      rdata_q  <= '0;
    end else begin
      if (accept) begin
        write_q  <= req_write;
        err_q    <= bad_req;
        funct3_q <= req_funct3;
        addr_q   <= req_addr;
        wdata_q  <= req_wdata;
      end
      if (state == RMW_READ) rmw_q <= mem_read_data;
      if (state == LOAD && !write_q) rdata_q <= load_data;
    end
  end

  lsu_lane_align #(.W(DATA_BUS_WIDTH)) u_align (
    .funct3     (funct3_q),
    .offset     (addr_q[1:0]),
    .rdata      (mem_read_data),
    .word_in    (rmw_q),
    .wdata      (wdata_q),
    .load_data  (load_data),
    .store_data (store_data)
  );

  assign req_ready      = (state == IDLE);
  assign rsp_valid      = (state == RESP);
  assign rsp_err        = (state == RESP) && err_q;
  assign rsp_rdata      = rdata_q;
  assign mem_addr       = (state == LOAD || state == RMW_READ || state == WRITE)
                          ? {addr_q[ADDR_BUS_WIDTH-1:2], 2'b00} : '0;
  assign mem_write_en   = (state == WRITE) && !reset;
  assign mem_write_data = (state == WRITE) ? store_data : '0;

endmodule
